serial_frame_tx: RTL and testbench

- Parallel-in, serial-out frame transmitter. It is the sending end of the team's single-wire serial link, whose receiver is built from D flip-flop shift stages.
- Accepts one WIDTH-bit word over a valid/ready handshake and serialises it on one line: start bit (0), data LSB first, optional parity, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a host/datapath producer and the physical tx line.

---
 rtl/serial_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Frame on tx_serial: start bit (0), WIDTH data bits LSB first, optional
// even-parity bit, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (adds the PARITY state).
//
// state  | meaning
// IDLE   | line high, tx_ready asserted while enabled
// START  | driving start bit (0)
// DATA   | driving data bit bit_idx_q (shreg_q[0])
// PARITY | driving stored parity bit (only with SERIAL_FRAME_TX_PARITY_EN)
// STOP   | driving stop bit (1); tx_done pulses after its last clock
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef SERIAL_FRAME_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_done_q, tx_done_d;
  logic             bit_end;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Ready only when idle, enabled and out of reset; an edge with reset_n low
  // never accepts, so ready is not advertised then.
  assign tx_ready  = enable && reset_n && (state_q == IDLE);
  assign tx_serial = tx_serial_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;
  assign bit_end   = (baud_q == LAST_CNT);

  // Next-state and next-output logic; everything holds while enable is low.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    tx_serial_d = tx_serial_q;
    tx_done_d   = tx_done_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    if (enable) begin
      tx_done_d = 1'b0;
      baud_d    = bit_end ? '0 : baud_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          tx_serial_d = 1'b1;
          baud_d      = '0;
          bit_idx_d   = '0;
          if (tx_valid && tx_ready) begin
            state_d     = START;
            shreg_d     = tx_data;
            tx_serial_d = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_d    = ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_d     = DATA;
            bit_idx_d   = '0;
            tx_serial_d = shreg_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_IDX) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              state_d     = PARITY;
              tx_serial_d = parity_q;
`else
              state_d     = STOP;
              tx_serial_d = 1'b1;
`endif
            end else begin
              shreg_d     = shreg_q >> 1;
              tx_serial_d = shreg_d[0];
              bit_idx_d   = bit_idx_q + IDX_W'(1);
            end
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_d     = STOP;
            tx_serial_d = 1'b1;
          end
        end
`endif
        STOP: begin
          tx_serial_d = 1'b1;
          if (bit_end) begin
            state_d   = IDLE;
            tx_done_d = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          tx_serial_d = 1'b1;
          baud_d      = '0;
        end
      endcase
    end
    tx_busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      tx_serial_q <= tx_serial_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx (WIDTH=8, CLKS_PER_BIT=4).
// Expected per-clock line levels are pushed to a queue when a word is offered
// and popped as the line is sampled on each falling edge.
module tb_serial_frame_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic exp_q[$];

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for every clock of one frame.
  task automatic push_frame(input logic [7:0] d);
    logic p;
    p = ^d;
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(d[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) exp_q.push_back(p);
`endif
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b1);
  endtask

  // Offer a word at the next falling edge and record its expected frame.
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    push_frame(d);
  endtask

  // Walk the frame one clock at a time, popping expected levels. Counts line
  // mismatches and cycles where ready/done/busy are not in their in-frame
  // values. Applies new inputs after the first sample, optional enable pause
  // and optional reset abort (which drops the rest of the expected frame).
  task automatic collect(input logic [7:0] nd, input logic nv,
                         input int pause_at, input int pause_len,
                         input int abort_at,
                         output int mism, output int ctl_bad);
    int   s;
    logic e;
    mism = 0; ctl_bad = 0; s = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (tx_serial !== e) mism++;
      if (tx_ready !== 1'b0 || tx_done !== 1'b0 || tx_busy !== 1'b1) ctl_bad++;
      if (s == 0) begin
        tx_data  = nd;
        tx_valid = nv;
      end
      if (s == pause_at) enable = 1'b0;
      if (s == pause_at + pause_len) enable = 1'b1;
      if (s == abort_at) begin
        reset_n = 1'b0;
        exp_q.delete();
      end
      s++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] v;
    reset_n  = 1'b0;
    enable   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v = {tx_serial, tx_busy, tx_done, tx_ready};
      tests_run++;
      if (v !== 4'b1000) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d] {serial,busy,done,ready} got %b want 1000", i, v);
      end
    end
    reset_n  = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1001) begin
      tests_failed++;
      $display("FAIL reset_release {serial,busy,done,ready} got %b want 1001", v);
    end
  endtask

  task automatic test_single_a5();
    int mism, ctl;
    logic [3:0] v;
    start_frame(8'hA5);
    collect(8'h5A, 1'b0, -1, 0, -1, mism, ctl);
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL a5_line mismatching clocks got %0d want 0", mism);
    end
    tests_run++;
    if (ctl !== 0) begin
      tests_failed++;
      $display("FAIL a5_ctrl bad ready/done/busy clocks got %0d want 0", ctl);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1011) begin
      tests_failed++;
      $display("FAIL a5_done {serial,busy,done,ready} got %b want 1011", v);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1001) begin
      tests_failed++;
      $display("FAIL a5_after {serial,busy,done,ready} got %b want 1001", v);
    end
  endtask

  task automatic test_back_to_back();
    int mism, ctl;
    logic [3:0] v;
    start_frame(8'h00);
    collect(8'hFF, 1'b1, -1, 0, -1, mism, ctl);
    tests_run++;
    if (mism !== 0 || ctl !== 0) begin
      tests_failed++;
      $display("FAIL b2b_first line/ctrl errors got %0d/%0d want 0/0", mism, ctl);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1011) begin
      tests_failed++;
      $display("FAIL b2b_done1 {serial,busy,done,ready} got %b want 1011", v);
    end
    push_frame(8'hFF);
    collect(8'h00, 1'b0, -1, 0, -1, mism, ctl);
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second_line mismatching clocks got %0d want 0", mism);
    end
    tests_run++;
    if (ctl !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second_ctrl bad clocks got %0d want 0", ctl);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1011) begin
      tests_failed++;
      $display("FAIL b2b_done2 {serial,busy,done,ready} got %b want 1011", v);
    end
  endtask

  task automatic test_enable_pause();
    int mism, ctl;
    logic [7:0] d;
    logic lvl;
    logic [3:0] v;
    d   = 8'h3C;
    lvl = d[3];
    start_frame(d);
    // data bit 3 covers samples 16..19; freeze after sample 17 for 5 clocks
    for (int i = 0; i < 5; i++) exp_q.insert(18, lvl);
    collect(8'hC3, 1'b0, 17, 5, -1, mism, ctl);
    tests_run++;
    if (mism !== 0) begin
      tests_failed++;
      $display("FAIL enable_line mismatching clocks got %0d want 0", mism);
    end
    tests_run++;
    if (ctl !== 0) begin
      tests_failed++;
      $display("FAIL enable_ctrl bad clocks got %0d want 0", ctl);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1011) begin
      tests_failed++;
      $display("FAIL enable_done {serial,busy,done,ready} got %b want 1011", v);
    end
  endtask

  task automatic test_reset_abort();
    int mism, ctl, bad;
    logic [3:0] v;
    start_frame(8'h81);
    // data bit 5 covers samples 24..27; reset asserted after sample 25
    collect(8'h00, 1'b0, -1, 0, 25, mism, ctl);
    tests_run++;
    if (mism !== 0 || ctl !== 0) begin
      tests_failed++;
      $display("FAIL abort_prefix line/ctrl errors got %0d/%0d want 0/0", mism, ctl);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1000) begin
      tests_failed++;
      $display("FAIL abort_edge {serial,busy,done,ready} got %b want 1000", v);
    end
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({tx_serial, tx_busy, tx_done, tx_ready} !== 4'b1001) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL abort_idle non-idle clocks got %0d want 0", bad);
    end
    start_frame(8'h55);
    collect(8'hAA, 1'b0, -1, 0, -1, mism, ctl);
    tests_run++;
    if (mism !== 0 || ctl !== 0) begin
      tests_failed++;
      $display("FAIL abort_55 line/ctrl errors got %0d/%0d want 0/0", mism, ctl);
    end
    @(negedge clk);
    v = {tx_serial, tx_busy, tx_done, tx_ready};
    tests_run++;
    if (v !== 4'b1011) begin
      tests_failed++;
      $display("FAIL abort_55_done {serial,busy,done,ready} got %b want 1011", v);
    end
  endtask

`ifdef SERIAL_FRAME_TX_PARITY_EN
  task automatic test_parity();
    int mism, ctl;
    logic [3:0] v;
    logic [7:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h07;
    for (int w = 0; w < 2; w++) begin
      start_frame(words[w]);
      collect(8'hFF, 1'b0, -1, 0, -1, mism, ctl);
      tests_run++;
      if (mism !== 0 || ctl !== 0) begin
        tests_failed++;
        $display("FAIL parity_%0h line/ctrl errors got %0d/%0d want 0/0", words[w], mism, ctl);
      end
      @(negedge clk);
      v = {tx_serial, tx_busy, tx_done, tx_ready};
      tests_run++;
      if (v !== 4'b1011) begin
        tests_failed++;
        $display("FAIL parity_%0h_done {serial,busy,done,ready} got %b want 1011", words[w], v);
      end
    end
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_enable_pause();
    test_reset_abort();
`ifdef SERIAL_FRAME_TX_PARITY_EN
    test_parity();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
